// File: rtl/jtag_read_arbiter.sv
// Arbitrates two source FIFOs into framed words shifted out on TDO: start 1, tag, data LSB first, stop 0.
// Define JTAG_READ_ARB_FIXED_PRIORITY_EN for fixed priority (source 0 wins); default is round-robin.
module jtag_read_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  TCK,
    input  logic                  nTRST,
    input  logic                  dr_shift,
    input  logic                  select,
    input  logic                  empty0,
    input  logic                  empty1,
    input  logic [DATA_WIDTH-1:0] rdata0,
    input  logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rinc0,
    output logic                  rinc1,
    output logic                  TDO,
    output logic                  busy,
    output logic                  grant
);
    localparam int FRAME_BITS = DATA_WIDTH + 3;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                state, state_nxt;
    logic [FRAME_BITS-1:0] sreg;
    logic [CNT_W-1:0]      cnt;
    logic                  shift_en;
    logic                  last_bit;
    logic                  take;
    logic                  winner;

    assign shift_en = dr_shift & select;
    assign last_bit = (cnt == LAST_CNT);
    assign TDO      = sreg[0];
    assign busy     = (state != IDLE);

`ifdef JTAG_READ_ARB_FIXED_PRIORITY_EN
    // Only consulted when at least one source has data.
    assign winner = empty0;
`else
    logic last_grant;

    always_comb begin
        if (!empty0 && !empty1) winner = ~last_grant;
        else                    winner = empty0;
    end

    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST)    last_grant <= 1'b1;
        else if (take) last_grant <= winner;
    end
`endif

    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        rinc0     = 1'b0;
        rinc1     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty0 || !empty1) begin
                    take      = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = SHIFT;
            SHIFT: begin
                if (shift_en && last_bit) begin
                    state_nxt = IDLE;
                    rinc0     = ~grant;
                    rinc1     = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The word is captured in LOAD, so later FIFO activity cannot disturb the frame in flight.
    always_ff @(posedge TCK or negedge nTRST) begin
        if (!nTRST) begin
            grant <= 1'b0;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            if (take) grant <= winner;
            case (state)
                LOAD: begin
                    sreg <= {1'b0, (grant ? rdata1 : rdata0), grant, 1'b1};
                    cnt  <= '0;
                end
                SHIFT: begin
                    if (shift_en) begin
                        sreg <= {1'b0, sreg[FRAME_BITS-1:1]};
                        cnt  <= last_bit ? '0 : cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_read_arbiter.sv
// Scoreboard bench for jtag_read_arbiter: a queue-based arbitration model predicts frames, a monitor checks TDO/rinc.
module tb_jtag_read_arbiter;
    localparam int DW = 8;
    localparam int FB = DW + 3;

    typedef struct {
        logic          src;
        logic [FB-1:0] bits;
    } frame_t;

    logic          TCK = 1'b0;
    logic          nTRST = 1'b0;
    logic          dr_shift = 1'b0;
    logic          select = 1'b0;
    logic          empty0 = 1'b1;
    logic          empty1 = 1'b1;
    logic [DW-1:0] rdata0 = '0;
    logic [DW-1:0] rdata1 = '0;
    logic          rinc0, rinc1, TDO, busy, grant;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] q0[$], q1[$], ql0[$], ql1[$];
    frame_t        exp_q[$];
    int            mode = 0;
    logic          glitch = 1'b0;

    jtag_read_arbiter #(.DATA_WIDTH(DW)) dut (
        .TCK(TCK), .nTRST(nTRST), .dr_shift(dr_shift), .select(select),
        .empty0(empty0), .empty1(empty1), .rdata0(rdata0), .rdata1(rdata1),
        .rinc0(rinc0), .rinc1(rinc1), .TDO(TDO), .busy(busy), .grant(grant)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // shift_en drive: 0 = held high, 1 = random, 2 = held low via select
    always @(posedge TCK) begin
        #1;
        case (mode)
            1: begin
                dr_shift = ($urandom_range(0, 3) != 0);
                select   = ($urandom_range(0, 7) != 0);
            end
            2: begin
                dr_shift = 1'b1;
                select   = 1'b0;
            end
            default: begin
                dr_shift = 1'b1;
                select   = 1'b1;
            end
        endcase
    end

    // Source FIFO models; glitch fakes empty/changed head on source 0 after the word was captured.
    always @(negedge TCK) begin
        if (nTRST && rinc0) begin
            if (q0.size() == 0) chk("underflow0", 1, 0);
            else q0.delete(0);
        end
        if (nTRST && rinc1) begin
            if (q1.size() == 0) chk("underflow1", 1, 0);
            else q1.delete(0);
        end
        empty0 = glitch || (q0.size() == 0);
        empty1 = (q1.size() == 0);
        rdata0 = (q0.size() > 0) ? (glitch ? ~q0[0] : q0[0]) : DW'($urandom);
        rdata1 = (q1.size() > 0) ? q1[0] : DW'($urandom);
    end

    // Monitor: first busy cycle is the load cycle; later busy cycles are shift cycles.
    logic   prev_busy = 1'b0;
    logic   hold = 1'b0;
    logic   hold_tdo = 1'b0;
    int     nbits = 0;
    int     gap = 0;
    frame_t cur;

    always @(negedge TCK) begin
        logic se, shift_cyc, ebit;
        if (!nTRST) begin
            chk("rst_tdo", TDO, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rinc", {rinc1, rinc0}, 0);
            chk("rst_grant", grant, 0);
            prev_busy = 1'b0;
            hold      = 1'b0;
            nbits     = 0;
            gap       = 0;
        end else begin
            se        = dr_shift & select;
            shift_cyc = busy && prev_busy;
            if (gap == 2) begin
                chk("b2b_load", busy, exp_q.size() > 0);
                gap = 0;
            end
            if (gap == 1) begin
                chk("gap_idle", busy, 0);
                gap = 2;
            end
            if (busy && !prev_busy) begin
                nbits = 0;
                if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
                else cur = exp_q[0];
            end
            if (!shift_cyc) begin
                chk("tdo_quiet", TDO, 0);
                chk("rinc_quiet", {rinc1, rinc0}, 0);
                hold = 1'b0;
            end else begin
                if (hold) chk("tdo_frozen", TDO, hold_tdo);
                chk("grant", grant, cur.src);
                if (se) begin
                    ebit = (nbits < FB) ? cur.bits[nbits] : 1'b0;
                    chk("tdo_bit", TDO, ebit);
                    nbits++;
                    chk("rinc", {rinc1, rinc0}, (nbits == FB) ? (cur.src ? 2 : 1) : 0);
                    if (nbits == FB && exp_q.size() > 0) begin
                        exp_q.delete(0);
                        gap = 1;
                    end
                    hold = 1'b0;
                end else begin
                    chk("rinc_hold", {rinc1, rinc0}, 0);
                    hold     = 1'b1;
                    hold_tdo = TDO;
                end
            end
            prev_busy = busy;
        end
    end

    // Reset, load FIFOs from ql0/ql1 and predict the full frame order from the arbitration rules.
    task automatic setup();
        int     i0 = 0;
        int     i1 = 0;
        logic   g;
        frame_t f;
`ifndef JTAG_READ_ARB_FIXED_PRIORITY_EN
        logic   last = 1'b1;
`endif
        @(posedge TCK);
        #2 nTRST = 1'b0;
        glitch = 1'b0;
        q0 = ql0;
        q1 = ql1;
        exp_q = {};
        while (i0 < ql0.size() || i1 < ql1.size()) begin
`ifdef JTAG_READ_ARB_FIXED_PRIORITY_EN
            g = (i0 < ql0.size()) ? 1'b0 : 1'b1;
`else
            if (i0 < ql0.size() && i1 < ql1.size()) g = ~last;
            else g = (i0 < ql0.size()) ? 1'b0 : 1'b1;
            last = g;
`endif
            f.src  = g;
            f.bits = {1'b0, (g ? ql1[i1] : ql0[i0]), g, 1'b1};
            if (g) i1++;
            else i0++;
            exp_q.push_back(f);
        end
        repeat (2) @(negedge TCK);
        @(posedge TCK);
        #2 nTRST = 1'b1;
    endtask

    task automatic wait_load();
        int c = 0;
        @(negedge TCK);
        while (!busy && c < 200) begin
            @(negedge TCK);
            c++;
        end
        if (!busy) chk("load_timeout", 1, 0);
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() > 0 && c < 4000) begin
            @(negedge TCK);
            c++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
        repeat (4) @(negedge TCK);
        chk("fifo_drained", q0.size() + q1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        mode = 0;
        ql0 = {8'hA5}; ql1 = {};
        setup(); drain();

        ql0 = {8'h11, 8'h11}; ql1 = {8'h22, 8'h22};
        setup(); drain();

        // shift_en dropped for five cycles mid-frame
        ql0 = {8'hC3}; ql1 = {};
        setup(); wait_load();
        repeat (4) @(negedge TCK);
        mode = 2;
        repeat (5) @(negedge TCK);
        mode = 0;
        drain();

        // reset after four shift bits; the word must be re-framed afterwards
        ql0 = {8'h5A}; ql1 = {};
        setup(); wait_load();
        repeat (4) @(negedge TCK);
        @(posedge TCK);
        #2 nTRST = 1'b0;
        repeat (3) @(negedge TCK);
        @(posedge TCK);
        #2 nTRST = 1'b1;
        drain();

        // source 0 looks empty with a different head once the frame is under way
        ql0 = {8'h3C}; ql1 = {};
        setup(); wait_load();
        @(negedge TCK);
        glitch = 1'b1;
        drain();
        glitch = 1'b0;

        mode = 1;
        ql0 = {}; ql1 = {};
        repeat (3) ql0.push_back(DW'($urandom));
        repeat (3) ql1.push_back(DW'($urandom));
        setup(); drain();

        for (int p = 0; p < 12; p++) begin
            int n0, n1;
            n0 = $urandom_range(0, 5);
            n1 = $urandom_range(0, 5);
            ql0 = {}; ql1 = {};
            repeat (n0) ql0.push_back(DW'($urandom));
            repeat (n1) ql1.push_back(DW'($urandom));
            setup(); drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_read_arbiter.md
JTAG_READ_ARBITER -- requirements
Module: jtag_read_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per FIFO word.
REQ-002 SHALL have port TCK  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port nTRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dr_shift  input  1  TAP in Shift-DR.
REQ-005 SHALL have port select  input  1  instruction register selects this data register.
REQ-006 SHALL have ports empty0, empty1  input  1 each  empty flags of source FIFOs 0 (AHB read data) and 1 (AHB status).
REQ-007 SHALL have ports rdata0, rdata1  input  DATA_WIDTH each  head word of each source FIFO.
REQ-008 SHALL have ports rinc0, rinc1  output  1 each  single-cycle pop strobes to the source FIFOs.
REQ-009 SHALL have port TDO  output  1  serial frame bit.
REQ-010 SHALL have port busy  output  1  high in LOAD and SHIFT.
REQ-011 SHALL have port grant  output  1  source owning the current or last frame.

Function
REQ-012 SHALL define FRAME_BITS = DATA_WIDTH+3, shifted LSB first as: start bit 1, tag bit (= grant), DATA_WIDTH data bits LSB first, stop bit 0.
REQ-013 SHALL define shift_en = dr_shift AND select.
REQ-014 SHALL implement states IDLE, LOAD and SHIFT.
REQ-015 IDLE: if either empty flag is low, SHALL latch the arbitration winner into grant and go to LOAD next cycle; otherwise SHALL stay in IDLE.
REQ-016 Arbitration: with one source non-empty, SHALL grant that source; with both non-empty, SHALL grant the source not granted last (round-robin).
REQ-017 LOAD: SHALL load the FRAME_BITS shift register from the granted rdata, clear the bit counter and go to SHIFT in exactly one cycle, regardless of shift_en.
REQ-018 SHIFT: on each cycle with shift_en, SHALL shift right by one, fill with 0 and increment the counter; with shift_en low, SHALL hold the shift register and counter.
REQ-019 TDO SHALL equal shift register bit 0 combinationally in every state; the shift register holds 0 outside an active frame.
REQ-020 When shift_en and counter == FRAME_BITS-1, SHALL assert rinc of the granted source for that cycle only and go to IDLE; the other rinc SHALL stay low.
REQ-021 Each frame SHALL produce exactly one rinc pulse; rinc SHALL never pulse outside SHIFT.
REQ-022 A change in empty flags or in rdata of the granted source after LOAD SHALL NOT alter the frame in flight.
REQ-023 The counter SHALL be ceil(log2(FRAME_BITS)) bits wide and SHALL NOT wrap within a frame.
REQ-024 Back-to-back frames SHALL be separated by exactly one IDLE and one LOAD cycle.

Reset
REQ-025 While nTRST is low: state = IDLE, shift register = 0, counter = 0, grant = 0, last-granted = 1, TDO = 0, busy = 0, rinc0 = rinc1 = 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no rinc pulse; the FIFO word remains queued.

Configuration
REQ-027 With macro JTAG_READ_ARB_FIXED_PRIORITY_EN defined, SHALL use fixed priority (source 0 always wins when non-empty) instead of REQ-016 round-robin.
REQ-028 With JTAG_READ_ARB_FIXED_PRIORITY_EN undefined, SHALL use round-robin per REQ-016; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, empty0=0, rdata0=0xA5, shift_en held high -> TDO sequence 1,0,1,0,1,0,0,1,0,1,0; rinc0 pulses once on the 11th shift cycle.
REQ-030 empty0=empty1=0, rdata0=0x11, rdata1=0x22, both continuously non-empty -> grants alternate 0,1,0,1; tag bit matches grant in each frame.
REQ-031 shift_en dropped for 5 cycles mid-frame -> TDO and counter frozen; frame resumes and completes with one rinc pulse.
REQ-032 nTRST pulsed low after 4 shift bits -> TDO=0, busy=0, no rinc; after release the same word is re-framed from its start bit.
REQ-033 empty0 rises and rdata0 changes after LOAD -> frame still carries the latched word, and rinc0 still fires at frame end.
REQ-034 JTAG_READ_ARB_FIXED_PRIORITY_EN defined, both sources non-empty for 3 frames -> grant = 0 for all 3 frames, rinc1 never pulses.
